score_mem_resp: RTL and testbench
=================================

SCORE_MEM_RESP -- requirements
Module: score_mem_resp

Interface
REQ-001 SHALL have parameter AW, default 10: log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: wait states per read data phase, legal range 0..15.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port HADDR  input  32: byte address from the BDMA master.
REQ-006 SHALL have port HTRANS  input  2: transfer type; HTRANS[1]=1 means NONSEQ/SEQ (active).
REQ-007 SHALL have port HWRITE  input  1: transfer direction; 1 means write.
REQ-008 SHALL have port HRDATA  output  32: read data, valid when HREADY=1 in a read data phase.
REQ-009 SHALL have port HREADY  output  1: transfer-done/accept strobe, shared by address and data phases.
REQ-010 SHALL have port ld_we  input  1: loader write strobe from CPU side.
REQ-011 SHALL have port ld_addr  input  AW: loader word address.
REQ-012 SHALL have port ld_wdata  input  32: loader write data.
REQ-013 SHALL have port wr_err  output  1: sticky flag, set by any AHB write attempt.
REQ-014 SHALL have port busy  output  1: high while a data phase is in progress (state not IDLE).

Function
REQ-015 SHALL accept an address phase when HTRANS[1]=1 and HREADY=1 on a rising edge.
REQ-016 SHALL use word address HADDR[AW+1:2]; HADDR[1:0] are ignored.
REQ-017 SHALL implement FSM IDLE/WAIT/DATA: accepted read -> WAIT if WAIT_CYCLES>0, else DATA.
REQ-018 SHALL drive HREADY=0 in WAIT for exactly WAIT_CYCLES cycles, via a 4-bit down-counter loaded at acceptance.
REQ-019 SHALL leave WAIT for DATA when the counter reaches 0.
REQ-020 SHALL drive HREADY=1 in DATA, with HRDATA holding the addressed word.
REQ-021 SHALL, in DATA, go to the next data phase if a new address phase is accepted in the same cycle (back-to-back pipelining), else return to IDLE.
REQ-022 SHALL drive HREADY=1 and hold HRDATA at its last value in IDLE.
REQ-023 SHALL use synchronous-read memory of 2^AW x 32; the read address is registered at acceptance and the read data captured into an HRDATA holding register.
REQ-024 SHALL give a read-to-data latency of exactly 1+WAIT_CYCLES cycles from the acceptance edge to the edge where HREADY=1 completes the transfer.
REQ-025 SHALL complete an accepted AHB write with the same timing as a read, set wr_err, leave memory unchanged and leave HRDATA unchanged.
REQ-026 SHALL accept loader writes in any state, one per cycle, written on the rising edge with ld_we=1.
REQ-027 SHALL, when a loader write and a read acceptance target the same word in the same cycle, return the old data (read-before-write).
REQ-028 SHALL return the loader data to a read accepted on any later cycle.
REQ-029 SHALL ignore address phases presented while HREADY=0; HADDR, HTRANS and HWRITE are not sampled in WAIT.

Reset
REQ-030 SHALL, while rst_n=0, force FSM=IDLE, counter=0, HREADY=1, HRDATA=32'h0, wr_err=0 and busy=0 asynchronously.
REQ-031 SHALL abandon any in-flight transfer on reset mid-operation without corrupting memory contents; memory is not cleared.
REQ-032 SHALL not clear wr_err except by reset.

Configuration
REQ-033 SHALL, with macro SCORE_MEM_BOUNDS_EN defined, return HRDATA=32'h0 (treated as the end-of-score word) for any read with HADDR[31:AW+2] nonzero, with normal timing.
REQ-034 SHALL, without SCORE_MEM_BOUNDS_EN, ignore HADDR[31:AW+2], so that reads alias modulo 2^(AW+2) bytes.

Verification
REQ-035 SHALL be verified by this scenario: WAIT_CYCLES=0; load word 5=32'h0000_0321; read HADDR=0x14 -> HREADY stays 1, HRDATA=0x0000_0321 on the next edge.
REQ-036 SHALL be verified by this scenario: WAIT_CYCLES=3; read word 5 -> HREADY=0 for 3 cycles, then 1 with HRDATA=0x0000_0321; busy high for 4 cycles.
REQ-037 SHALL be verified by this scenario: back-to-back reads of 0x14 and 0x18 (word 6=0x0000_0412), WAIT_CYCLES=1 -> data 0x321 then 0x412; no idle cycle between the phases.
REQ-038 SHALL be verified by this scenario: same-cycle loader write of 0xAAAA to word 5 and read of word 5 -> returns 0x321; next read returns 0xAAAA.
REQ-039 SHALL be verified by this scenario: AHB write to 0x20 -> wr_err=1, word 8 unchanged; assert rst_n=0 during WAIT -> HREADY=1, HRDATA=0, wr_err=0 immediately.
REQ-040 SHALL be verified by this scenario: AW=10, read HADDR=0x1014 -> with SCORE_MEM_BOUNDS_EN HRDATA=0x0; without it, HRDATA=0x0000_0321.

Source files
------------

// File: rtl/score_mem_resp.sv
// Score memory AHB-style read responder with loader write port and WAIT_CYCLES wait states.
// Optional SCORE_MEM_BOUNDS_EN: reads above the 2^(AW+2)-byte window return 32'h0.
module score_mem_resp #(
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  output logic [31:0]   HRDATA,
  output logic          HREADY,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          wr_err,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   mem [0:(2**AW)-1];
  logic [AW-1:0] word_addr;
  logic          accept;
  logic          oob;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign word_addr   = HADDR[AW+1:2];
  assign accept      = HTRANS[1] & HREADY;
  assign unused_bits = ^{HTRANS[0], HADDR[1:0], HADDR[31:AW+2]};

`ifdef SCORE_MEM_BOUNDS_EN
  assign oob = |HADDR[31:AW+2];
`else
  assign oob = 1'b0;
`endif

  assign rd_word = oob ? 32'h0 : mem[word_addr];

  // Loader port is independent of the bus FSM; no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_wdata;
  end

  // The synchronous read happens on the acceptance edge, so a same-edge loader
  // write to that word is not yet visible (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      HREADY <= 1'b1;
      HRDATA <= 32'h0;
      wr_err <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state  <= S_DATA;
            HREADY <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            if (HWRITE) wr_err <= 1'b1;
            else        HRDATA <= rd_word;
            busy <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state  <= S_WAIT;
              cnt    <= CNT_LOAD;
              HREADY <= 1'b0;
            end else begin
              state  <= S_DATA;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_mem_resp.sv
// Directed bench for score_mem_resp: three instances (0, 1 and 3 wait states) on one shared bus.
module tb_score_mem_resp;

  logic        clk;
  logic        rst_n;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_wdata;

  logic [31:0] hd0, hd1, hd3;
  logic        hr0, hr1, hr3;
  logic        we0, we1, we3;
  logic        bz0, bz1, bz3;

  int tests = 0;
  int fails = 0;

  score_mem_resp #(.AW(10), .WAIT_CYCLES(0)) d0 (
    .clk(clk), .rst_n(rst_n), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(hd0), .HREADY(hr0), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .wr_err(we0), .busy(bz0));

  score_mem_resp #(.AW(10), .WAIT_CYCLES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(hd1), .HREADY(hr1), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .wr_err(we1), .busy(bz1));

  score_mem_resp #(.AW(10), .WAIT_CYCLES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(hd3), .HREADY(hr3), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .wr_err(we3), .busy(bz3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_read(input logic [31:0] a);
    HADDR = a; HTRANS = 2'b10; HWRITE = 1'b0;
  endtask

  task automatic bus_idle();
    HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic settle();
    bus_idle();
    repeat (6) @(negedge clk);
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_wdata = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (hr0 !== 1'b1)  begin fails++; $display("FAIL reset_hready got %b want 1", hr0); end
    tests++; if (hd0 !== 32'h0) begin fails++; $display("FAIL reset_hrdata got %h want 0", hd0); end
    tests++; if (we0 !== 1'b0)  begin fails++; $display("FAIL reset_wr_err got %b want 0", we0); end
    tests++; if (bz0 !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", bz0); end
  endtask

  task automatic test_zero_wait();
    drive_read(32'h14);
    @(negedge clk); bus_idle();
    tests++; if (hr0 !== 1'b1) begin fails++; $display("FAIL zw_hready got %b want 1", hr0); end
    tests++; if (hd0 !== 32'h321) begin fails++; $display("FAIL zw_data got %h want 00000321", hd0); end
    tests++; if (bz0 !== 1'b1) begin fails++; $display("FAIL zw_busy got %b want 1", bz0); end
    @(negedge clk);
    tests++; if (bz0 !== 1'b0) begin fails++; $display("FAIL zw_idle_busy got %b want 0", bz0); end
    tests++; if (hd0 !== 32'h321) begin fails++; $display("FAIL zw_hold got %h want 00000321", hd0); end
    settle();
  endtask

  task automatic test_wait_states();
    drive_read(32'h14);
    @(negedge clk);
    // Present a different phase while HREADY is low; it must not be sampled.
    drive_read(32'h18);
    for (int i = 0; i < 3; i++) begin
      tests++; if (hr3 !== 1'b0) begin fails++; $display("FAIL ws_hready_low[%0d] got %b want 0", i, hr3); end
      tests++; if (bz3 !== 1'b1) begin fails++; $display("FAIL ws_busy[%0d] got %b want 1", i, bz3); end
      if (i == 2) bus_idle();
      @(negedge clk);
    end
    tests++; if (hr3 !== 1'b1) begin fails++; $display("FAIL ws_hready_done got %b want 1", hr3); end
    tests++; if (hd3 !== 32'h321) begin fails++; $display("FAIL ws_data got %h want 00000321", hd3); end
    tests++; if (bz3 !== 1'b1) begin fails++; $display("FAIL ws_busy_data got %b want 1", bz3); end
    @(negedge clk);
    tests++; if (bz3 !== 1'b0) begin fails++; $display("FAIL ws_busy_end got %b want 0", bz3); end
    settle();
  endtask

  task automatic test_back_to_back();
    drive_read(32'h14);
    @(negedge clk);
    drive_read(32'h18);
    tests++; if (hr1 !== 1'b0) begin fails++; $display("FAIL b2b_wait1 got %b want 0", hr1); end
    @(negedge clk);
    tests++; if (hr1 !== 1'b1) begin fails++; $display("FAIL b2b_ready1 got %b want 1", hr1); end
    tests++; if (hd1 !== 32'h321) begin fails++; $display("FAIL b2b_data1 got %h want 00000321", hd1); end
    @(negedge clk); bus_idle();
    tests++; if (hr1 !== 1'b0) begin fails++; $display("FAIL b2b_wait2 got %b want 0", hr1); end
    tests++; if (bz1 !== 1'b1) begin fails++; $display("FAIL b2b_no_idle got %b want 1", bz1); end
    @(negedge clk);
    tests++; if (hr1 !== 1'b1) begin fails++; $display("FAIL b2b_ready2 got %b want 1", hr1); end
    tests++; if (hd1 !== 32'h412) begin fails++; $display("FAIL b2b_data2 got %h want 00000412", hd1); end
    settle();
  endtask

  task automatic test_read_before_write();
    drive_read(32'h14);
    ld_we = 1'b1; ld_addr = 10'd5; ld_wdata = 32'h0000_AAAA;
    @(negedge clk);
    ld_we = 1'b0;
    tests++; if (hd0 !== 32'h321) begin fails++; $display("FAIL rbw_old got %h want 00000321", hd0); end
    @(negedge clk); bus_idle();
    tests++; if (hd0 !== 32'hAAAA) begin fails++; $display("FAIL rbw_new got %h want 0000aaaa", hd0); end
    settle();
  endtask

  task automatic test_write_err();
    tests++; if (we1 !== 1'b0) begin fails++; $display("FAIL werr_before got %b want 0", we1); end
    HADDR = 32'h20; HTRANS = 2'b10; HWRITE = 1'b1;
    @(negedge clk); bus_idle();
    tests++; if (we1 !== 1'b1) begin fails++; $display("FAIL werr_set got %b want 1", we1); end
    tests++; if (hr1 !== 1'b0) begin fails++; $display("FAIL werr_wait got %b want 0", hr1); end
    @(negedge clk);
    tests++; if (hr1 !== 1'b1) begin fails++; $display("FAIL werr_done got %b want 1", hr1); end
    tests++; if (hd1 !== 32'h321) begin fails++; $display("FAIL werr_hrdata got %h want 00000321", hd1); end
    settle();
    tests++; if (we1 !== 1'b1) begin fails++; $display("FAIL werr_sticky got %b want 1", we1); end
  endtask

  task automatic test_reset_mid_wait();
    drive_read(32'h18);
    @(negedge clk); bus_idle();
    tests++; if (hr3 !== 1'b0) begin fails++; $display("FAIL rst_pre_wait got %b want 0", hr3); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (hr3 !== 1'b1)  begin fails++; $display("FAIL rst_hready got %b want 1", hr3); end
    tests++; if (hd3 !== 32'h0) begin fails++; $display("FAIL rst_hrdata got %h want 0", hd3); end
    tests++; if (we3 !== 1'b0)  begin fails++; $display("FAIL rst_wr_err got %b want 0", we3); end
    tests++; if (bz3 !== 1'b0)  begin fails++; $display("FAIL rst_busy got %b want 0", bz3); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    drive_read(32'h20);
    @(negedge clk); bus_idle();
    tests++; if (hd0 !== 32'h800) begin fails++; $display("FAIL mem_word8 got %h want 00000800", hd0); end
    settle();
    drive_read(32'h14);
    @(negedge clk); bus_idle();
    tests++; if (hd0 !== 32'hAAAA) begin fails++; $display("FAIL mem_word5 got %h want 0000aaaa", hd0); end
    settle();
  endtask

  task automatic test_bounds();
    logic [31:0] exp;
`ifdef SCORE_MEM_BOUNDS_EN
    exp = 32'h0;
`else
    exp = 32'h321;
`endif
    load(10'd5, 32'h321);
    drive_read(32'h1014);
    @(negedge clk); bus_idle();
    tests++; if (hr0 !== 1'b1) begin fails++; $display("FAIL bounds_hready got %b want 1", hr0); end
    tests++; if (hd0 !== exp) begin fails++; $display("FAIL bounds_data got %h want %h", hd0, exp); end
    settle();
  endtask

  initial begin
    rst_n = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    @(negedge clk);
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    load(10'd5, 32'h321);
    load(10'd6, 32'h412);
    load(10'd8, 32'h800);
    test_zero_wait();
    test_wait_states();
    test_back_to_back();
    test_read_before_write();
    test_write_err();
    test_reset_mid_wait();
    test_bounds();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
